// File: rtl/mop_accum_ctrl.sv
// Serial multi-operand accumulator controller: folds a programmable count of
// operands through one W-bit adder and hands the total out on a valid/ready port.
module mop_accum_ctrl #(
  parameter  int N  = 20,
  parameter  int K  = 8,
  localparam int W  = N + $clog2(K),
  localparam int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  input  logic          op_valid,
  input  logic [N-1:0]  op_data,
  output logic          op_ready,
  output logic          sum_valid,
  output logic [W-1:0]  sum_out,
  input  logic          sum_ready,
  output logic          busy,
  output logic [CW-1:0] ops_left
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CW-1:0] KMAX = CW'(K);

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] left_q, left_d;

  // sum_q is separate from acc_q so the published result stays put while the
  // next job clears and rebuilds the accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    left_d  = left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = '0;
          left_d = (num_ops > KMAX) ? KMAX : num_ops;
          if (left_d == '0) begin
            sum_d   = '0;
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (op_valid) begin
          acc_d  = acc_q + W'(op_data);
          left_d = left_q - CW'(1);
          if (left_q == CW'(1)) begin
            sum_d   = acc_d;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      left_q  <= left_d;
    end
  end

  assign op_ready  = (state_q == ACCUM);
  assign sum_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_q;
  assign ops_left  = left_q;

endmodule

// File: doc/mop_accum_ctrl.md
# mop_accum_ctrl

Sequencing controller for the shared N-bit ripple-carry adder in the multi-operand adder path. It accepts a programmable count of operands, one per cycle, over a valid/ready stream and folds each into a widened accumulator through a single adder. It then presents the final sum on a valid/ready result port. It sits between the operand source and downstream consumers, so a serial accumulation can stand in for a full adder tree when area matters more than latency.

## Interface
- N, default 20: operand width in bits.
- K, default 8: maximum operands per job; must be ≥ 2.
- Derived W = N + clog2(K) (23 at defaults): accumulator and result width.
- Derived CW = clog2(K+1) (4 at defaults): width of the operand-count field.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- num_ops  in  CW  operand count for the job; captured with start.
- op_valid  in  1  operand present.
- op_data  in  N  unsigned operand.
- op_ready  out  1  controller accepts an operand this cycle.
- sum_valid  out  1  result available.
- sum_out  out  W  accumulated sum, zero-extended.
- sum_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.
- ops_left  out  CW  operands still to be accepted in the current job.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE, start=1:
  - Clear acc to 0.
  - Set ops_left to num_ops, saturated at K when num_ops > K.
  - If that value is 0, go to DONE; otherwise go to ACCUM.
- IDLE, start=0: remain in IDLE.
- ACCUM:
  - op_ready=1.
  - On each op_valid & op_ready cycle: acc ← acc + zero-extended op_data (W-bit add, no wrap possible by construction), and ops_left decrements by 1.
  - If this handshake takes ops_left from 1 to 0, go to DONE.
  - Cycles with op_valid=0 change nothing.
- DONE:
  - sum_valid=1 and sum_out=acc, both stable until handshake.
  - op_ready=0.
  - On sum_ready=1, go to IDLE.
- start is ignored in ACCUM and DONE; it is not queued.
- op_valid is ignored outside ACCUM. No operand is consumed and op_data is not examined.
- sum_out holds its last value in IDLE and ACCUM. Only sum_valid qualifies it.
- Reset, including asynchronous assertion mid-job, forces:
  - state = IDLE
  - acc = 0, ops_left = 0
  - op_ready = 0, sum_valid = 0, busy = 0
  - sum_out = 0
  - Any partial job is discarded.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from an input to an output.
- Start accepted at edge t: busy=1 from t+1. op_ready=1 from t+1 unless num_ops=0.
- num_ops=0: sum_valid=1 at t+1 with sum_out=0.
- Throughput: one operand per cycle while op_valid is held high.
- Last operand accepted at edge e: acc holds the final sum and sum_valid=1 from e+1.
- Minimum job latency, start edge to sum_valid: num_ops+1 cycles.
- Result handshake at edge h: IDLE at h+1, and the earliest next start is sampled at h+1.
- One idle cycle between jobs is required and accepted.
- Adder path: one W-bit ripple add per cycle. The target clock must cover W full-adder delays.

## Test plan
- Job with num_ops=3 and operands 1, 2, 3 on consecutive cycles: sum_valid rises 4 cycles after start with sum_out=6; ops_left steps 3→2→1→0.
- Job with num_ops=8 and all operands 0xFFFFF: sum_out=0x7FFFF8 with no truncation. Repeat with num_ops=15: count clamps to 8 and the same sum results.
- Job with num_ops=0: sum_valid=1 one cycle after start with sum_out=0; op_ready never asserts.
- Operand bubbles with num_ops=4 and operand pattern 5, gap, gap, 7, gap, 9, 11: sum_out=32 and nothing is accumulated on gap cycles. Then hold sum_ready=0 for 5 cycles: sum_valid and sum_out stay stable, and a start pulse during DONE is ignored (busy stays 1, no new job).
- Reset mid-job: assert rst asynchronously after 2 of 5 operands. Outputs go to 0 immediately, with no wait for a clock edge. A new job with num_ops=2 and operands 10, 20 then returns 30, with no residue from the aborted job.
- Back-to-back jobs: hold sum_ready=1 and start=1 continuously. Each job completes, the controller spends exactly one cycle in IDLE between jobs, and the second job's sum is independent of the first.
